// File: rtl/vdac_stream_pkg.sv
// Shared types for the vdac streaming front-end.
package vdac_stream_pkg;

  // Sequencer states, encoded in two bits.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Largest positive code for a given DAC width: sign bit 0, all others 1.
  function automatic int unsigned max_code_val(input int unsigned bitwidth);
    return (32'd1 << (bitwidth - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/vdac_fifo.sv
// Sample buffer: power-of-2 depth, synchronous reset, head exposed combinationally.
module vdac_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [WIDTH-1:0]               i_data,
  output logic [WIDTH-1:0]               o_data,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  always_comb begin
    push_ok  = i_push & ~o_full;
    pop_ok   = i_pop & ~o_empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; storage itself needs no reset.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vdac_stream.sv
// Streaming front-end for the tri-state-inverter voltage DAC array:
// FIFO buffering, paced sample release and first-order error-feedback shaping.
module vdac_stream
  import vdac_stream_pkg::*;
#(
  parameter int BITWIDTH   = 6,
  parameter int EXTRA_BITS = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_enable,
  input  logic [DIV_WIDTH-1:0]                i_div,
  input  logic [BITWIDTH+EXTRA_BITS-1:0]      i_sample,
  input  logic                                i_valid,
  output logic                                o_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_level,
  output logic [BITWIDTH-1:0]                 o_dac_data,
  output logic                                o_dac_enable,
  output logic                                o_underrun
);

  localparam int W  = BITWIDTH + EXTRA_BITS;
  localparam int EW = (EXTRA_BITS > 0) ? EXTRA_BITS : 1;
  localparam logic [BITWIDTH-1:0] MAX_CODE = BITWIDTH'(max_code_val(BITWIDTH));

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [W-1:0]         held_q, held_d;
  logic [EW-1:0]        err_q, err_d;
  logic [BITWIDTH-1:0]  dac_data_q, dac_data_d;
  logic                 dac_enable_q, dac_enable_d;
  logic                 underrun_q, underrun_d;

  logic                 fifo_full, fifo_empty, push, pop, tick;
  logic [W-1:0]         fifo_head;
  logic [W:0]           sum;
  logic                 overflow;
  logic [BITWIDTH-1:0]  shape_code;
  logic [EW-1:0]        shape_err;

  assign o_ready = ~fifo_full;
  assign push    = i_valid & o_ready;

  vdac_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (i_sample),
    .o_data  (fifo_head),
    .o_count (o_level),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // err is never negative, so only the positive side can exceed the code range.
  assign sum      = {held_q[W-1], held_q} + {{(W + 1 - EW){1'b0}}, err_q};
  assign overflow = ~sum[W] & sum[W-1];

  if (EXTRA_BITS > 0) begin : g_shape
    assign shape_code = sum[W-1:EXTRA_BITS];
    assign shape_err  = sum[EW-1:0];
  end else begin : g_trunc
    assign shape_code = sum[W-1:0];
    assign shape_err  = '0;
  end

  assign tick = (state_q != ST_IDLE) && (div_q == i_div);

  // Next-state: sequencer, update-period divider, held sample and shaper.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    held_d       = held_q;
    err_d        = err_q;
    dac_data_d   = dac_data_q;
    dac_enable_d = dac_enable_q;
    underrun_d   = 1'b0;
    pop          = 1'b0;
    if (!i_enable) begin
      state_d      = ST_IDLE;
      div_d        = '0;
      held_d       = '0;
      err_d        = '0;
      dac_data_d   = '0;
      dac_enable_d = 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        div_d = '0;
      end else if (div_q >= i_div) begin
        div_d = '0;
      end else begin
        div_d = div_q + DIV_WIDTH'(1);
      end
      case (state_q)
        ST_IDLE: state_d = ST_PRIME;
        ST_PRIME: begin
          if (tick && !fifo_empty) begin
            pop          = 1'b1;
            held_d       = fifo_head;
            state_d      = ST_RUN;
            dac_enable_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (tick) begin
            if (!fifo_empty) begin
              pop    = 1'b1;
              held_d = fifo_head;
            end else begin
              underrun_d = 1'b1;
            end
          end
          if (overflow) begin
            dac_data_d = MAX_CODE;
            err_d      = '0;
          end else begin
            dac_data_d = shape_code;
            err_d      = shape_err;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // All sequencer state and registered outputs; reset takes priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      held_q       <= '0;
      err_q        <= '0;
      dac_data_q   <= '0;
      dac_enable_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      held_q       <= held_d;
      err_q        <= err_d;
      dac_data_q   <= dac_data_d;
      dac_enable_q <= dac_enable_d;
      underrun_q   <= underrun_d;
    end
  end

  assign o_dac_data   = dac_data_q;
  assign o_dac_enable = dac_enable_q;
  assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_vdac_stream.sv
// Directed bench for vdac_stream with a queue of expected DAC codes.
module tb_vdac_stream;

  logic       i_clk;
  logic       i_rst;
  logic       i_enable;
  logic [7:0] i_div;
  logic [7:0] i_sample;
  logic       i_valid;
  logic       o_ready;
  logic [2:0] o_level;
  logic [5:0] o_dac_data;
  logic       o_dac_enable;
  logic       o_underrun;

  int n_cmp = 0;
  int n_mis = 0;
  int m_err = 0;
  logic [5:0] exp_q[$];
  logic       ur_q[$];

  vdac_stream #(
    .BITWIDTH   (6),
    .EXTRA_BITS (2),
    .FIFO_DEPTH (4),
    .DIV_WIDTH  (8)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_div        (i_div),
    .i_sample     (i_sample),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_level      (o_level),
    .o_dac_data   (o_dac_data),
    .o_dac_enable (o_dac_enable),
    .o_underrun   (o_underrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_sample(input logic [7:0] v);
    i_sample = v;
    i_valid  = 1'b1;
    step();
    i_valid  = 1'b0;
  endtask

  // Shaper reference: held sample plus carried error, clamp or split.
  task automatic push_model(input logic signed [7:0] s, input int reps);
    for (int i = 0; i < reps; i++) begin
      int sum;
      logic [5:0] c;
      sum = s;
      sum = sum + m_err;
      if (sum > 127) begin
        c     = 6'h1F;
        m_err = 0;
      end else begin
        c     = 6'(sum >>> 2);
        m_err = sum & 3;
      end
      exp_q.push_back(c);
    end
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (o_dac_enable !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("dac_enable_rise", {31'd0, o_dac_enable}, 32'd1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      logic [5:0] e;
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("dac_data", {26'd0, o_dac_data}, {26'd0, e});
      end
      if (ur_q.size() > 0) begin
        logic u;
        u = ur_q.pop_front();
        check("underrun", {31'd0, o_underrun}, {31'd0, u});
      end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst    = 1'b1;
    i_enable = 1'b0;
    i_div    = 8'd0;
    i_sample = 8'd0;
    i_valid  = 1'b0;
    step();
    step();
    check("rst_data",     {26'd0, o_dac_data},   32'd0);
    check("rst_enable",   {31'd0, o_dac_enable}, 32'd0);
    check("rst_level",    {29'd0, o_level},      32'd0);
    check("rst_ready",    {31'd0, o_ready},      32'd1);
    check("rst_underrun", {31'd0, o_underrun},   32'd0);
    i_rst = 1'b0;
    step();

    // Fill while idle, then drain in order; the refused 0x55 never appears.
    m_err = 0;
    push_model(8'h11, 1);
    push_model(8'h22, 1);
    push_model(8'h33, 1);
    push_model(8'h44, 2);
    push_sample(8'h11);
    push_sample(8'h22);
    push_sample(8'h33);
    push_sample(8'h44);
    check("fill_level", {29'd0, o_level}, 32'd4);
    check("fill_ready", {31'd0, o_ready}, 32'd0);
    push_sample(8'h55);
    check("full_refuse_level", {29'd0, o_level}, 32'd4);
    i_div    = 8'd0;
    i_enable = 1'b1;
    wait_en();
    step();
    drain(5);
    i_enable = 1'b0;
    step();
    check("dis_enable",   {31'd0, o_dac_enable}, 32'd0);
    check("dis_data",     {26'd0, o_dac_data},   32'd0);
    check("dis_underrun", {31'd0, o_underrun},   32'd0);
    check("dis_level",    {29'd0, o_level},      32'd0);

    // Pacing at i_div=3, then underrun pulses once per empty tick.
    push_sample(8'h40);
    push_sample(8'hC0);
    check("pace_level", {29'd0, o_level}, 32'd2);
    i_div = 8'd3;
    m_err = 0;
    push_model(8'h40, 4);
    push_model(8'hC0, 8);
    for (int i = 0; i < 7; i++) ur_q.push_back(1'b0);
    ur_q.push_back(1'b1);
    for (int i = 0; i < 3; i++) ur_q.push_back(1'b0);
    ur_q.push_back(1'b1);
    i_enable = 1'b1;
    wait_en();
    step();
    drain(12);
    i_enable = 1'b0;
    step();
    check("pace_dis_enable", {31'd0, o_dac_enable}, 32'd0);
    check("pace_dis_data",   {26'd0, o_dac_data},   32'd0);

    // FIFO contents survive a PRIME -> IDLE round trip.
    push_sample(8'h7F);
    push_sample(8'h7F);
    check("keep_level_before", {29'd0, o_level}, 32'd2);
    i_enable = 1'b1;
    step();
    step();
    i_enable = 1'b0;
    step();
    check("keep_level_after", {29'd0, o_level},      32'd2);
    check("keep_enable",      {31'd0, o_dac_enable}, 32'd0);

    // Saturation: 0x7F twice then 0x80.
    i_div = 8'd0;
    push_sample(8'h80);
    check("sat_level", {29'd0, o_level}, 32'd3);
    check("sat_ready", {31'd0, o_ready}, 32'd1);
    m_err = 0;
    push_model(8'h7F, 2);
    push_model(8'h80, 2);
    i_enable = 1'b1;
    wait_en();
    step();
    drain(4);
    i_enable = 1'b0;
    step();

    // Shaping: constant 0x05 kept flowing, push and pop every cycle.
    i_sample = 8'h05;
    i_valid  = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("shape_full", {29'd0, o_level}, 32'd4);
    m_err = 0;
    push_model(8'h05, 8);
    i_enable = 1'b1;
    wait_en();
    step();
    drain(8);
    check("shape_level_steady", {29'd0, o_level}, 32'd3);

    // Reset in the middle of RUN.
    i_valid = 1'b0;
    i_rst   = 1'b1;
    step();
    step();
    check("mid_rst_data",     {26'd0, o_dac_data},   32'd0);
    check("mid_rst_enable",   {31'd0, o_dac_enable}, 32'd0);
    check("mid_rst_level",    {29'd0, o_level},      32'd0);
    check("mid_rst_ready",    {31'd0, o_ready},      32'd1);
    check("mid_rst_underrun", {31'd0, o_underrun},   32'd0);
    i_rst    = 1'b0;
    i_enable = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
